// File: rtl/wb_arb5.sv
// Five-channel Wishbone bus arbiter: channel 4 has strict priority, channels 0-3 rotate.
// Grants are held for the whole cyc period, with one dead cycle between any two grants.
module wb_arb5 #(
  parameter int TIMEOUT = 1023
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       wbs_cyc0,
  input  logic       wbs_cyc1,
  input  logic       wbs_cyc2,
  input  logic       wbs_cyc3,
  input  logic       wbs_cyc4,
  input  logic       wbm_ack_i,
  input  logic       wbm_err_i,
  input  logic       wbm_rty_i,
  output logic [4:0] gnt,
  output logic       arb_busy,
  output logic       arb_timeout,
  output logic [1:0] gnt_last
);

  localparam int          NUM_RR = 4;
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  w_cyc;
  logic [4:0]  r_gnt, w_gnt_nxt;
  logic [1:0]  r_last, w_last_nxt;
  logic [15:0] r_wd, w_wd_nxt;
  logic        r_busy;
  logic        r_timeout, w_timeout_nxt;
  logic        w_sel_vld;
  logic [2:0]  w_sel_idx;
  logic [1:0]  w_rr_idx;
  logic        w_gnt_cyc;
  logic        w_release;

  assign w_cyc     = {wbs_cyc4, wbs_cyc3, wbs_cyc2, wbs_cyc1, wbs_cyc0};
  assign w_gnt_cyc = |(r_gnt & w_cyc);
  assign w_release = !w_gnt_cyc || wbm_rty_i || (r_wd == TO_LIM);

  // Walk from farthest to nearest so the channel right after r_last wins.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = 3'd0;
    w_rr_idx  = 2'd0;
    if (w_cyc[4]) begin
      w_sel_vld = 1'b1;
      w_sel_idx = 3'd4;
    end else begin
      for (int i = NUM_RR; i >= 1; i--) begin
        w_rr_idx = r_last + 2'(i);
        if (w_cyc[w_rr_idx]) begin
          w_sel_vld = 1'b1;
          w_sel_idx = {1'b0, w_rr_idx};
        end
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_last_nxt    = r_last;
    w_wd_nxt      = r_wd;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_GRANT: begin
        if (w_release) begin
          w_state_nxt   = S_GAP;
          w_gnt_nxt     = '0;
          w_wd_nxt      = '0;
          w_timeout_nxt = w_gnt_cyc && !wbm_rty_i;
        end else if (wbm_ack_i || wbm_err_i) begin
          w_wd_nxt = '0;
        end else if (r_wd != TO_LIM) begin
          w_wd_nxt = r_wd + 16'd1;
        end
      end
      default: begin
        w_gnt_nxt = '0;
        w_wd_nxt  = '0;
        if (w_sel_vld) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = 5'b00001 << w_sel_idx;
          if (!w_sel_idx[2]) w_last_nxt = w_sel_idx[1:0];
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_gnt     <= '0;
      r_last    <= 2'd3;
      r_wd      <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_gnt     <= w_gnt_nxt;
      r_last    <= w_last_nxt;
      r_wd      <= w_wd_nxt;
      r_busy    <= (w_state_nxt == S_GRANT);
      r_timeout <= w_timeout_nxt;
    end
  end

  assign gnt         = r_gnt;
  assign arb_busy    = r_busy;
  assign arb_timeout = r_timeout;
  assign gnt_last    = r_last;

  a_gnt_onehot: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_i)
    $onehot0(r_gnt));
  a_busy_gnt: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_i)
    r_busy == (|r_gnt));
  a_to_idle: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_i)
    r_timeout |-> (r_gnt == 5'd0));

endmodule

// File: tb/tb_wb_arb5.sv
// Bench for wb_arb5: owner/pointer model checked every cycle plus directed literal checks.
module tb_wb_arb5;
  localparam int TO = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] cyc   = '0;
  logic       ack   = 1'b0;
  logic       err   = 1'b0;
  logic       rty   = 1'b0;
  logic [4:0] gnt;
  logic       busy;
  logic       tmo;
  logic [1:0] last;

  int n_checks = 0;
  int n_errors = 0;

  // Model: who owns the bus (-1 = nobody), rotation pointer, watchdog, timeout pulse.
  int m_owner = -1;
  int m_ptr   = 3;
  int m_wd    = 0;
  bit m_to    = 1'b0;

  wb_arb5 #(.TIMEOUT(TO)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst_n),
    .wbs_cyc0   (cyc[0]),
    .wbs_cyc1   (cyc[1]),
    .wbs_cyc2   (cyc[2]),
    .wbs_cyc3   (cyc[3]),
    .wbs_cyc4   (cyc[4]),
    .wbm_ack_i  (ack),
    .wbm_err_i  (err),
    .wbm_rty_i  (rty),
    .gnt        (gnt),
    .arb_busy   (busy),
    .arb_timeout(tmo),
    .gnt_last   (last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] onehot(input int idx);
    logic [4:0] v;
    v = 5'd1;
    return (idx < 0) ? 5'd0 : (v << idx);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 3;
      m_wd    = 0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner >= 0) begin
        if (!cyc[m_owner] || rty || m_wd == TO) begin
          m_to    = cyc[m_owner] && !rty;
          m_owner = -1;
          m_wd    = 0;
        end else if (ack || err) begin
          m_wd = 0;
        end else if (m_wd < TO) begin
          m_wd++;
        end
      end else begin
        m_wd = 0;
        if (cyc[4]) begin
          m_owner = 4;
        end else begin
          for (int k = 1; k <= 4; k++) begin
            if (cyc[(m_ptr + k) % 4]) begin
              m_owner = (m_ptr + k) % 4;
              m_ptr   = m_owner;
              break;
            end
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("m_gnt", gnt, onehot(m_owner));
    chk("m_busy", busy, 16'(m_owner >= 0));
    chk("m_timeout", tmo, 16'(m_to));
    chk("m_gnt_last", last, 16'(m_ptr));
  end

  initial begin
    // Reset values and round-robin from reset
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", tmo, 0);
    chk("rst_last", last, 3);
    cyc[3:0] = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rr_first_gnt", gnt, 5'b00001);
    chk("rr_first_last", last, 0);
    for (int c = 0; c < 4; c++) begin
      ack = 1'b1;
      repeat (4) @(negedge clk);
      ack    = 1'b0;
      cyc[c] = 1'b0;
      @(negedge clk);
      chk("rr_gap", gnt, 0);
      @(negedge clk);
      if (c < 3) begin
        chk("rr_gnt", gnt, 5'd1 << (c + 1));
        chk("rr_last", last, 16'(c + 1));
      end else begin
        chk("rr_idle", gnt, 0);
        chk("rr_idle_last", last, 3);
      end
    end

    // Channel 4 priority never preempts, and does not move the pointer
    cyc[1] = 1'b1;
    @(negedge clk);
    chk("prio_gnt1", gnt, 5'b00010);
    cyc[4] = 1'b1;
    cyc[2] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("prio_hold", gnt, 5'b00010);
    end
    cyc[1] = 1'b0;
    @(negedge clk);
    chk("prio_gap", gnt, 0);
    @(negedge clk);
    chk("prio_gnt4", gnt, 5'b10000);
    chk("prio_last", last, 1);
    @(negedge clk);
    chk("prio_gnt4_hold", gnt, 5'b10000);
    cyc[4] = 1'b0;
    @(negedge clk);
    chk("prio_gap2", gnt, 0);
    @(negedge clk);
    chk("prio_gnt2", gnt, 5'b00100);
    chk("prio_last2", last, 2);
    cyc[2] = 1'b0;
    repeat (2) @(negedge clk);

    // Retry rotates past a still-requesting channel; channel 4 may be re-granted
    cyc[1:0] = 2'b11;
    @(negedge clk);
    chk("rty_gnt0", gnt, 5'b00001);
    rty = 1'b1;
    @(negedge clk);
    rty = 1'b0;
    chk("rty_gap", gnt, 0);
    chk("rty_no_to", tmo, 0);
    @(negedge clk);
    chk("rty_gnt1", gnt, 5'b00010);
    chk("rty_last", last, 1);
    cyc[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rty_back0", gnt, 5'b00001);
    cyc[0] = 1'b0;
    repeat (2) @(negedge clk);
    cyc[4] = 1'b1;
    @(negedge clk);
    chk("rty4_gnt", gnt, 5'b10000);
    rty = 1'b1;
    @(negedge clk);
    rty = 1'b0;
    chk("rty4_gap", gnt, 0);
    @(negedge clk);
    chk("rty4_regnt", gnt, 5'b10000);
    chk("rty4_last", last, 0);
    cyc[4] = 1'b0;
    repeat (2) @(negedge clk);

    // Watchdog: 9 cycles of grant, then one-cycle timeout pulse
    cyc[3] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("to_hold", gnt, 5'b01000);
      chk("to_hold_pulse", tmo, 0);
    end
    @(negedge clk);
    chk("to_rel", gnt, 0);
    chk("to_pulse", tmo, 1);
    @(negedge clk);
    chk("to_regnt", gnt, 5'b01000);
    chk("to_pulse_end", tmo, 0);
    for (int k = 2; k <= 15; k++) begin
      @(negedge clk);
      if (k <= 14) begin
        chk("ack_restart_hold", gnt, 5'b01000);
      end else begin
        chk("ack_restart_rel", gnt, 0);
        chk("ack_restart_pulse", tmo, 1);
      end
      if (k == 5) ack = 1'b1;
      if (k == 6) ack = 1'b0;
    end
    cyc[3] = 1'b0;
    @(negedge clk);
    chk("to_idle", gnt, 0);
    chk("to_idle_pulse", tmo, 0);

    // Error keeps the grant and clears the watchdog; then async reset mid-grant
    cyc[2] = 1'b1;
    @(negedge clk);
    chk("err_gnt", gnt, 5'b00100);
    err = 1'b1;
    for (int k = 2; k <= 13; k++) begin
      @(negedge clk);
      chk("err_hold", gnt, 5'b00100);
    end
    err = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_last", last, 3);
    cyc[2] = 1'b0;
    cyc[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt", gnt, 5'b00001);
    chk("post_rst_last", last, 0);
    cyc[0] = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
